// File: rtl/ascii_seq_pkg.sv
// ---------------------------------------------------------------------------
// ascii_seq_pkg
// Shared definitions for the ASCII sequencing controller:
//   CHAR_W   - width of an ASCII character code
//   PAT_W    - width of the decoder output pattern (Sa..Sk)
//   NUL_CODE - character that is consumed but never presented to the decoder
//   state_t  - sequencing FSM state encoding
// ---------------------------------------------------------------------------
package ascii_seq_pkg;

    localparam int CHAR_W = 7;
    localparam int PAT_W  = 11;
    localparam logic [CHAR_W-1:0] NUL_CODE = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DWELL   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // True when a character is the NUL filler that must be skipped.
    function automatic logic is_nul(input logic [CHAR_W-1:0] c);
        return (c == NUL_CODE);
    endfunction

endpackage

// File: rtl/ascii_fifo.sv
// ---------------------------------------------------------------------------
// ascii_fifo
// Character queue with extra-MSB pointers (full = MSBs differ, LSBs equal).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the queue)
//   push, din   - write din at the tail when not full
//   pop         - drop the head when not empty
//   full, empty - occupancy flags
//   dout        - current head entry
// ---------------------------------------------------------------------------
module ascii_fifo #(
    parameter int DEPTH  = 4,
    parameter int CHAR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [CHAR_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CHAR_W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [CHAR_W-1:0] mem_r [DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic              do_push_s;
    logic              do_pop_s;

    // A full queue refuses writes even when a pop happens in the same cycle.
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Storage array; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ascii_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ascii_seq_ctrl
// Queues ASCII characters and presents them one at a time to an external
// truthtable decoder, waits a programmable settle time, then captures the
// decoder pattern.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable              - allows a new character to start
//   in_valid/in_ready   - producer handshake, in_char is the offered code
//   dwell               - settle cycles, sampled in LOAD
//   code                - registered code to decoder inputs A..G (A = MSB)
//   dec_pat             - decoder outputs Sa..Sk (Sa = MSB)
//   out_pat, out_valid  - captured pattern and its one-cycle strobe
//   busy                - FSM is not IDLE
// ---------------------------------------------------------------------------
module ascii_seq_ctrl
    import ascii_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHAR_W-1:0]  in_char,
    input  logic [DWELL_W-1:0] dwell,
    output logic [CHAR_W-1:0]  code,
    input  logic [PAT_W-1:0]   dec_pat,
    output logic [PAT_W-1:0]   out_pat,
    output logic               out_valid,
    output logic               busy
);

    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};

    state_t             state_r;
    state_t             state_next_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_next_s;
    logic [CHAR_W-1:0]  code_r;
    logic [PAT_W-1:0]   out_pat_r;
    logic               out_valid_r;
    logic               ready_en_r;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CHAR_W-1:0]  fifo_dout_s;
    logic               push_s;
    logic               pop_s;
    logic               code_load_s;
    logic               capture_s;
    logic               start_s;

    // ready_en_r keeps in_ready low through reset and the release edge.
    assign in_ready  = ready_en_r & ~fifo_full_s;
    assign push_s    = in_valid & in_ready;
    assign start_s   = enable & ~fifo_empty_s;
    assign code      = code_r;
    assign out_pat   = out_pat_r;
    assign out_valid = out_valid_r;
    assign busy      = (state_r != ST_IDLE);

    ascii_fifo #(
        .DEPTH  (DEPTH),
        .CHAR_W (CHAR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (in_char),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_dout_s)
    );

    // Next-state and control decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pop_s        = 1'b0;
        code_load_s  = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    pop_s = 1'b1;
                    // A NUL head is consumed without touching code.
                    if (is_nul(fifo_dout_s)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        code_load_s  = 1'b1;
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_next_s   = dwell;
                state_next_s = ST_DWELL;
            end
            ST_DWELL: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                capture_s = 1'b1;
                if (start_s) begin
                    pop_s = 1'b1;
                    // A NUL head drops back to IDLE so code never shows it.
                    if (is_nul(fifo_dout_s)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        code_load_s  = 1'b1;
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, dwell counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            code_r      <= NUL_CODE;
            out_pat_r   <= {PAT_W{1'b0}};
            out_valid_r <= 1'b0;
            ready_en_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            ready_en_r  <= 1'b1;
            out_valid_r <= capture_s;
            if (code_load_s) code_r    <= fifo_dout_s;
            if (capture_s)   out_pat_r <= dec_pat;
        end
    end

endmodule
